// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the M-extension divide path.
package muldiv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Sign-extend a W-form result from bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]};
    endfunction

endpackage

// File: rtl/div_ovf_detect.sv
// Flags the signed-overflow case (most-negative / -1) for 64-bit and W forms.
module div_ovf_detect
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            word_i,
    input  logic            signed_i,
    output logic            ovf_c_o
);

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [WLEN-1:0] MIN_W = {1'b1, {(WLEN-1){1'b0}}};

    logic ovf_x_c;
    logic ovf_w_c;

    assign ovf_x_c = (a_i == MIN_X) && (&b_i);
    assign ovf_w_c = (a_i[WLEN-1:0] == MIN_W) && (&b_i[WLEN-1:0]);
    assign ovf_c_o = signed_i && (word_i ? ovf_w_c : ovf_x_c);

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage sequencer for the iterative divider: operand handoff,
// signed-overflow bypass, result select/extension and output hold.
module div_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = muldiv_pkg::XLEN,
    parameter bit          BYPASS_OVF = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy,
    output logic            div_start,
    output logic            div_signed,
    output logic            div_word,
    output logic            div_next,
    output logic [XLEN-1:0] div_numerator,
    output logic [XLEN-1:0] div_denominator,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    input  logic            div_done
);

    localparam int unsigned PW      = muldiv_pkg::XLEN;
    localparam logic [1:0]  ST_IDLE = 2'(IDLE);
    localparam logic [1:0]  ST_BUSY = 2'(BUSY);
    localparam logic [1:0]  ST_DONE = 2'(DONE);

    logic [1:0]      state_q, state_d;
    div_op_t         op_q, op_d;
    logic            word_q, word_d;
    logic            signed_q, signed_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            div_start_q, div_start_d;
    logic            div_next_q, div_next_d;

    logic            in_signed_c;
    logic            ovf_c;
    logic [XLEN-1:0] sel_c;

    assign in_signed_c = (in_op == 2'(DIV)) || (in_op == 2'(REM));
    assign sel_c       = ((op_q == REM) || (op_q == REMU)) ? div_remainder : div_quotient;

    div_ovf_detect #(
        .XLEN (XLEN)
    ) u_ovf (
        .a_i      (in_a),
        .b_i      (in_b),
        .word_i   (in_word),
        .signed_i (in_signed_c),
        .ovf_c_o  (ovf_c)
    );

    // Next-state, operand latch and result capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        word_d     = word_q;
        signed_d   = signed_q;
        a_d        = a_q;
        b_d        = b_q;
        out_data_d = out_data_q;
        div_next_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d     = div_op_t'(in_op);
                    word_d   = in_word;
                    signed_d = in_signed_c;
                    a_d      = in_a;
                    b_d      = in_b;
                    if (BYPASS_OVF && ovf_c) begin
                        state_d = ST_DONE;
                        if (in_op == 2'(REM)) begin
                            out_data_d = '0;
                        end else begin
                            out_data_d = in_word ? XLEN'(sext32(PW'(in_a))) : in_a;
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (div_done) begin
                    out_data_d = word_q ? XLEN'(sext32(PW'(sel_c))) : sel_c;
                    div_next_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over any same-cycle accept, completion or drain.
        if (flush) begin
            state_d    = ST_IDLE;
            op_d       = op_q;
            word_d     = word_q;
            signed_d   = signed_q;
            a_d        = a_q;
            b_d        = b_q;
            out_data_d = out_data_q;
            div_next_d = 1'b1;
        end

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        div_start_d = (state_d == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= DIV;
            word_q      <= 1'b0;
            signed_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            div_start_q <= 1'b0;
            div_next_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            word_q      <= word_d;
            signed_q    <= signed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            div_start_q <= div_start_d;
            div_next_q  <= div_next_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign busy            = busy_q;
    assign div_start       = div_start_q;
    assign div_next        = div_next_q;
    assign div_signed      = signed_q;
    assign div_word        = word_q;
    assign div_numerator   = a_q;
    assign div_denominator = b_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl against a RISC-V divide reference model,
// with the iterative divider emulated inline.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_word, out_ready, div_done;
    logic [1:0]  in_op;
    logic [63:0] in_a, in_b, div_quotient, div_remainder;
    logic        in_ready, out_valid, busy, div_start, div_signed, div_word, div_next;
    logic [63:0] out_data, div_numerator, div_denominator;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_word         (in_word),
        .in_a            (in_a),
        .in_b            (in_b),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .busy            (busy),
        .div_start       (div_start),
        .div_signed      (div_signed),
        .div_word        (div_word),
        .div_next        (div_next),
        .div_numerator   (div_numerator),
        .div_denominator (div_denominator),
        .div_quotient    (div_quotient),
        .div_remainder   (div_remainder),
        .div_done        (div_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // RISC-V M-extension result for op (0=DIV 1=DIVU 2=REM 3=REMU).
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        int          sa, sb;
        longint      la, lb;
        logic [63:0] r;
        a32 = a[31:0];
        b32 = b[31:0];
        sa  = a32;
        sb  = b32;
        la  = a;
        lb  = b;
        r   = '0;
        r32 = '0;
        if (w) begin
            case (op)
                2'd0: if (b32 == 0) r32 = 32'hFFFF_FFFF;
                      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
                      else r32 = sa / sb;
                2'd1: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
                2'd2: if (b32 == 0) r32 = a32;
                      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 0;
                      else r32 = sa % sb;
                default: r32 = (b32 == 0) ? a32 : a32 % b32;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                2'd0: if (b == 0) r = '1;
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                      else r = la / lb;
                2'd1: r = (b == 0) ? '1 : a / b;
                2'd2: if (b == 0) r = a;
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 0;
                      else r = la % lb;
                default: r = (b == 0) ? a : a % b;
            endcase
        end
        return r;
    endfunction

    function automatic logic is_bypass(input logic [1:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        if (op == 2'd1 || op == 2'd3) return 1'b0;
        if (w) return (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        return (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", in_ready, 1);
    endtask

    task automatic accept(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_op    = op;
        in_word  = w;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
    endtask

    // Full transaction: accept, divider emulation, backpressure, drain.
    task automatic do_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input int lat, input int hold);
        logic [63:0] exp, q, r;
        logic        byp, sgn;
        exp = ref_div(op, w, a, b);
        byp = is_bypass(op, w, a, b);
        sgn = (op == 2'd0) || (op == 2'd2);
        accept(op, w, a, b);
        if (byp) begin
            check("bypass_no_start", div_start, 0);
        end else begin
            check("start", div_start, 1);
            check("numerator", div_numerator, a);
            check("denominator", div_denominator, b);
            check("div_signed", div_signed, sgn);
            check("div_word", div_word, w);
            for (int i = 0; i < lat; i++) begin
                check("busy_no_valid", out_valid, 0);
                @(negedge clk);
            end
            q = ref_div(div_signed ? 2'd0 : 2'd1, div_word, div_numerator, div_denominator);
            r = ref_div(div_signed ? 2'd2 : 2'd3, div_word, div_numerator, div_denominator);
            if (div_word) begin
                q[63:32] = $urandom;
                r[63:32] = $urandom;
            end
            div_quotient  = q;
            div_remainder = r;
            div_done      = 1'b1;
            @(negedge clk);
            div_done      = 1'b0;
            div_quotient  = {$urandom, $urandom};
            div_remainder = {$urandom, $urandom};
            check("next_pulse", div_next, 1);
        end
        check("valid", out_valid, 1);
        check("data", out_data, exp);
        check("in_ready_done", in_ready, 0);
        check("start_done", div_start, 0);
        if (byp) check("bypass_no_next", div_next, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, exp);
            check("hold_in_ready", in_ready, 0);
            check("hold_next", div_next, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_word = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0; div_done = 1'b0;
        div_quotient = '0; div_remainder = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_start", div_start, 0);
        check("rst_next", div_next, 1);
        check("rst_numerator", div_numerator, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_next", div_next, 0);

        do_op(2'd0, 1'b0, -64'sd7, 64'd2, 4, 0);
        do_op(2'd2, 1'b0, -64'sd7, 64'd2, 2, 0);
        do_op(2'd3, 1'b0, 64'd7, 64'd2, 0, 1);
        do_op(2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 3, 0);
        do_op(2'd1, 1'b0, 64'd5, 64'd0, 1, 0);
        do_op(2'd2, 1'b0, 64'd5, 64'd0, 1, 0);
        do_op(2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 0);
        do_op(2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 0);
        do_op(2'd0, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF, 0, 2);
        do_op(2'd1, 1'b0, 64'd1000, 64'd3, 2, 3);

        // Flush ten cycles into BUSY.
        accept(2'd1, 1'b0, 64'd1000, 64'd3);
        repeat (9) @(negedge clk);
        check("busy_before_flush", div_start, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_start", div_start, 0);
        check("flush_next", div_next, 1);
        check("flush_in_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        @(negedge clk);
        check("flush_next_once", div_next, 0);
        do_op(2'd1, 1'b0, 64'd100, 64'd7, 3, 0);

        // Flush in DONE drops the pending result.
        accept(2'd0, 1'b0, 64'h8000_0000_0000_0000, '1);
        check("done_valid_pre_flush", out_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("done_flush_valid", out_valid, 0);
        check("done_flush_next", div_next, 1);

        // Flush beats a same-cycle accept.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = 2'd1; in_a = 64'd9; in_b = 64'd3;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_vs_accept_busy", busy, 0);
        check("flush_vs_accept_start", div_start, 0);

        // Reset mid-operation clears the operand registers.
        accept(2'd0, 1'b0, 64'd77, 64'd5);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_start", div_start, 0);
        check("midrst_next", div_next, 1);
        check("midrst_numerator", div_numerator, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 1);

        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 64'h8000_0000_0000_0000;
                1: a = {$urandom, 32'h8000_0000};
                2: a = 64'($urandom_range(0, 200));
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0: b = '1;
                1: b = '0;
                2: b = 64'($urandom_range(1, 20));
                default: b = {$urandom, $urandom};
            endcase
            do_op(op, w, a, b, $urandom_range(0, 6), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
